// File: rtl/mode_arbiter.sv
// Mode and audio-source arbiter: debounced mode keys, timed sub-system reset
// pulse, and a muting multiplexer from the per-mode audio streams to the audio core.
module mode_arbiter #(
  parameter int                   NUM_MODES       = 4,
  parameter int                   MODE_W          = 2,
  parameter int                   SW_W            = 10,
  parameter int                   AUDIO_W         = 32,
  parameter int                   DEBOUNCE_CYCLES = 50000,
  parameter int                   RESET_PULSE     = 16,
  parameter logic [NUM_MODES-1:0] SILENT_MASK     = 4'b0100
) (
  input  logic                         CLOCK_50,
  input  logic                         resetn,
  input  logic [NUM_MODES-1:0]         mode_key_n,
  input  logic [SW_W-1:0]              sw,
  input  logic                         enable,
  input  logic [NUM_MODES-1:0]         src_write,
  input  logic [NUM_MODES*AUDIO_W-1:0] src_sound,
  input  logic                         audio_out_allowed,
  output logic [MODE_W-1:0]            mode,
  output logic                         mode_change,
  output logic                         sub_reset,
  output logic [NUM_MODES-1:0]         src_allowed,
  output logic                         write_audio_out,
  output logic [AUDIO_W-1:0]           sound
);

  localparam int              DB_W    = $clog2(DEBOUNCE_CYCLES);
  localparam logic [DB_W-1:0] DB_MAX  = DB_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [DB_W-1:0] DB_ACC  = DB_W'(DEBOUNCE_CYCLES - 2);
  localparam int              RP_W    = $clog2(RESET_PULSE + 1);
  localparam logic [RP_W-1:0] RP_LOAD = RP_W'(RESET_PULSE - 1);

  typedef enum logic {S_IDLE, S_PULSE} rst_state_t;

  logic [NUM_MODES-1:0] key_s1, key_s2;
  logic [SW_W-1:0]      sw_s1, sw_s2, sw_prev;
  logic                 en_s1, en_s2;
  logic [NUM_MODES-1:0] key_p, key_p_prev;
  logic [DB_W-1:0]      db_cnt;
  logic [MODE_W-1:0]    cand;
  logic                 accept;
  logic                 change_sw;
  rst_state_t           state, state_next;
  logic [RP_W-1:0]      count, count_next;
  logic                 trig;
  logic                 mute;

  // Two-flop synchronisers; keys idle released (high), enable idles low so outputs stay muted
  always_ff @(posedge CLOCK_50 or negedge resetn) begin
    if (!resetn) begin
      key_s1 <= '1;
      key_s2 <= '1;
      sw_s1  <= '0;
      sw_s2  <= '0;
      en_s1  <= 1'b0;
      en_s2  <= 1'b0;
    end else begin
      key_s1 <= mode_key_n;
      key_s2 <= key_s1;
      sw_s1  <= sw;
      sw_s2  <= sw_s1;
      en_s1  <= enable;
      en_s2  <= en_s1;
    end
  end

  assign key_p = ~key_s2;

  // Lowest pressed index wins when several keys are held together
  always_comb begin
    cand = '0;
    for (int i = NUM_MODES - 1; i >= 0; i--) begin
      if (key_p[i]) cand = MODE_W'(i);
    end
  end

  assign accept = (key_p == key_p_prev) && (db_cnt == DB_ACC) && (key_p != '0);

  always_ff @(posedge CLOCK_50 or negedge resetn) begin
    if (!resetn) begin
      key_p_prev  <= '0;
      db_cnt      <= '0;
      mode        <= '0;
      mode_change <= 1'b0;
      sw_prev     <= '0;
      change_sw   <= 1'b0;
    end else begin
      key_p_prev  <= key_p;
      mode_change <= 1'b0;
      if (key_p != key_p_prev) begin
        db_cnt <= '0;
      end else if (db_cnt != DB_MAX) begin
        db_cnt <= db_cnt + 1'b1;
      end
      if (accept && (cand != mode)) begin
        mode        <= cand;
        mode_change <= 1'b1;
      end
      sw_prev   <= sw_s2;
      change_sw <= (sw_s2 != sw_prev);
    end
  end

  assign trig = change_sw | mode_change;

  always_ff @(posedge CLOCK_50 or negedge resetn) begin
    if (!resetn) begin
      state <= S_PULSE;
      count <= RP_LOAD;
    end else begin
      state <= state_next;
      count <= count_next;
    end
  end

  // A trigger during the pulse reloads the count, so the pulse only ever extends
  always_comb begin
    state_next = state;
    count_next = count;
    case (state)
      S_IDLE: begin
        if (trig) begin
          state_next = S_PULSE;
          count_next = RP_LOAD;
        end
      end
      S_PULSE: begin
        if (trig) begin
          count_next = RP_LOAD;
        end else if (count == '0) begin
          state_next = S_IDLE;
        end else begin
          count_next = count - 1'b1;
        end
      end
      default: begin
        state_next = S_IDLE;
        count_next = '0;
      end
    endcase
  end

  assign sub_reset       = (state == S_PULSE) | ~en_s2;
  assign mute            = sub_reset | SILENT_MASK[mode];
  assign write_audio_out = src_write[mode] & audio_out_allowed & ~mute;
  assign sound           = mute ? '0 : src_sound[mode*AUDIO_W +: AUDIO_W];
  assign src_allowed     = (NUM_MODES'(1) << mode) & {NUM_MODES{audio_out_allowed & ~mute}};

endmodule

// File: tb/tb_mode_arbiter.sv
// Directed self-checking bench for mode_arbiter with a short debounce (4) and pulse (3).
module tb_mode_arbiter;

  localparam int NUM_MODES = 4;
  localparam int MODE_W    = 2;
  localparam int SW_W      = 10;
  localparam int AUDIO_W   = 32;

  logic                         clk;
  logic                         resetn;
  logic [NUM_MODES-1:0]         mode_key_n;
  logic [SW_W-1:0]              sw;
  logic                         enable;
  logic [NUM_MODES-1:0]         src_write;
  logic [NUM_MODES*AUDIO_W-1:0] src_sound;
  logic                         audio_out_allowed;
  logic [MODE_W-1:0]            mode;
  logic                         mode_change;
  logic                         sub_reset;
  logic [NUM_MODES-1:0]         src_allowed;
  logic                         write_audio_out;
  logic [AUDIO_W-1:0]           sound;

  int vectors;
  int miscompares;
  logic saw_mc, saw_sr;

  mode_arbiter #(
    .NUM_MODES(NUM_MODES), .MODE_W(MODE_W), .SW_W(SW_W), .AUDIO_W(AUDIO_W),
    .DEBOUNCE_CYCLES(4), .RESET_PULSE(3), .SILENT_MASK(4'b0100)
  ) dut (
    .CLOCK_50(clk), .resetn(resetn), .mode_key_n(mode_key_n), .sw(sw),
    .enable(enable), .src_write(src_write), .src_sound(src_sound),
    .audio_out_allowed(audio_out_allowed), .mode(mode), .mode_change(mode_change),
    .sub_reset(sub_reset), .src_allowed(src_allowed),
    .write_audio_out(write_audio_out), .sound(sound)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check_value(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Hold a key pattern until the debounced mode updates, then follow the reset pulse
  task automatic press_keys(input logic [3:0] keys, input logic [1:0] old_mode,
                            input logic [1:0] new_mode, input string tag);
    mode_key_n = keys;
    repeat (5) tick();
    check_value({tag, "_mode_before"}, 32'(mode), 32'(old_mode));
    check_value({tag, "_mc_before"}, 32'(mode_change), 32'd0);
    tick();
    check_value({tag, "_mode_after"}, 32'(mode), 32'(new_mode));
    check_value({tag, "_mc_pulse"}, 32'(mode_change), 32'd1);
    check_value({tag, "_sr_not_yet"}, 32'(sub_reset), 32'd0);
    tick();
    check_value({tag, "_mc_one_cycle"}, 32'(mode_change), 32'd0);
    check_value({tag, "_sr_1"}, 32'(sub_reset), 32'd1);
    check_value({tag, "_sound_muted"}, sound, 32'd0);
    check_value({tag, "_write_muted"}, 32'(write_audio_out), 32'd0);
    tick();
    check_value({tag, "_sr_2"}, 32'(sub_reset), 32'd1);
    tick();
    check_value({tag, "_sr_3"}, 32'(sub_reset), 32'd1);
    tick();
    check_value({tag, "_sr_end"}, 32'(sub_reset), 32'd0);
    mode_key_n = 4'b1111;
  endtask

  initial begin
    vectors     = 0;
    miscompares = 0;
    resetn      = 1'b0;
    mode_key_n  = 4'b1111;
    sw          = '0;
    enable      = 1'b1;
    src_write   = 4'b0111;
    src_sound   = '0;
    src_sound[0*AUDIO_W +: AUDIO_W] = 32'hAAAA_5555;
    src_sound[1*AUDIO_W +: AUDIO_W] = 32'h1234_5678;
    src_sound[2*AUDIO_W +: AUDIO_W] = 32'hDEAD_BEEF;
    src_sound[3*AUDIO_W +: AUDIO_W] = 32'h0F0F_0F0F;
    audio_out_allowed = 1'b1;

    repeat (2) tick();
    check_value("rst_mode", 32'(mode), 32'd0);
    check_value("rst_mc", 32'(mode_change), 32'd0);
    check_value("rst_sr", 32'(sub_reset), 32'd1);
    check_value("rst_write", 32'(write_audio_out), 32'd0);

    // Power-up pulse
    resetn = 1'b1;
    #1;
    check_value("pwr_sr_0", 32'(sub_reset), 32'd1);
    check_value("pwr_sound_0", sound, 32'd0);
    tick();
    check_value("pwr_sr_1", 32'(sub_reset), 32'd1);
    check_value("pwr_sound_1", sound, 32'd0);
    tick();
    check_value("pwr_sr_2", 32'(sub_reset), 32'd1);
    tick();
    check_value("pwr_sr_end", 32'(sub_reset), 32'd0);
    check_value("pwr_mode", 32'(mode), 32'd0);
    check_value("m0_sound", sound, 32'hAAAA_5555);
    check_value("m0_allowed", 32'(src_allowed), 32'h1);

    // Mode 1 selection and audio routing
    press_keys(4'b1101, 2'd0, 2'd1, "key1");
    check_value("m1_sound", sound, 32'h1234_5678);
    check_value("m1_write", 32'(write_audio_out), 32'd1);
    check_value("m1_allowed", 32'(src_allowed), 32'b0010);
    audio_out_allowed = 1'b0;
    #1;
    check_value("m1_write_blocked", 32'(write_audio_out), 32'd0);
    check_value("m1_allowed_blocked", 32'(src_allowed), 32'd0);
    audio_out_allowed = 1'b1;
    tick();

    // Bouncing key 2 never settles long enough to be accepted
    saw_mc = 1'b0;
    saw_sr = 1'b0;
    for (int i = 0; i < 10; i++) begin
      mode_key_n[2] = i[0];
      repeat (2) begin
        tick();
        saw_mc |= mode_change;
        saw_sr |= sub_reset;
      end
    end
    repeat (8) begin
      tick();
      saw_mc |= mode_change;
      saw_sr |= sub_reset;
    end
    check_value("bounce_mode", 32'(mode), 32'd1);
    check_value("bounce_no_mc", 32'(saw_mc), 32'd0);
    check_value("bounce_no_sr", 32'(saw_sr), 32'd0);

    // Silent mode 2
    press_keys(4'b1011, 2'd1, 2'd2, "key2");
    check_value("m2_sound", sound, 32'd0);
    check_value("m2_write", 32'(write_audio_out), 32'd0);
    check_value("m2_allowed", 32'(src_allowed), 32'd0);
    repeat (3) tick();

    // Two switch changes two cycles apart merge into one extended pulse
    sw[3] = 1'b1;
    tick();
    check_value("sw_sr_p1", 32'(sub_reset), 32'd0);
    tick();
    check_value("sw_sr_p2", 32'(sub_reset), 32'd0);
    sw[5] = 1'b1;
    tick();
    check_value("sw_sr_p3", 32'(sub_reset), 32'd0);
    for (int k = 4; k <= 8; k++) begin
      tick();
      check_value($sformatf("sw_sr_p%0d", k), 32'(sub_reset), 32'd1);
    end
    tick();
    check_value("sw_sr_p9", 32'(sub_reset), 32'd0);

    // Keys 0 and 3 together resolve to mode 0
    press_keys(4'b0110, 2'd2, 2'd0, "key03");
    check_value("m0_write_again", 32'(write_audio_out), 32'd1);

    // Enable low forces sub_reset through the synchroniser
    enable = 1'b0;
    tick();
    check_value("en_sr_d1", 32'(sub_reset), 32'd0);
    tick();
    check_value("en_sr_d2", 32'(sub_reset), 32'd1);
    check_value("en_write_off", 32'(write_audio_out), 32'd0);
    check_value("en_sound_off", sound, 32'd0);
    repeat (3) tick();
    check_value("en_sr_hold", 32'(sub_reset), 32'd1);
    enable = 1'b1;
    tick();
    check_value("en_sr_r1", 32'(sub_reset), 32'd1);
    tick();
    check_value("en_sr_r2", 32'(sub_reset), 32'd0);
    check_value("en_write_back", 32'(write_audio_out), 32'd1);

    // Asynchronous reset mid-operation
    press_keys(4'b1101, 2'd0, 2'd1, "key1b");
    check_value("pre_rst_write", 32'(write_audio_out), 32'd1);
    #2;
    resetn = 1'b0;
    #1;
    check_value("arst_mode", 32'(mode), 32'd0);
    check_value("arst_sr", 32'(sub_reset), 32'd1);
    check_value("arst_write", 32'(write_audio_out), 32'd0);
    check_value("arst_sound", sound, 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
